i2s_rx_deser: RTL and testbench

I2S_RX_DESER -- requirements
Module: i2s_rx_deser

---
 rtl/i2s_rx_deser.sv | 200 ++++++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
// ---------------------------------------------------------------------------
// i2s_rx_deser
//
// I2S receiver / deserializer. The serial bit clock is oversampled by clk_i;
// each SCK rising edge samples WS and SD. Words are MSB-aligned into a DW-bit
// shift register. A left/right pair is handed to the consumer through a
// valid/ready holding stage. A pair that completes while the previous one is
// still waiting is dropped and flagged on the sticky ovf_o.
//
// Build option:
//   I2S_RX_SYNC_EN  defined   -> sck_i, ws_i and sd_i each pass through a
//                                2-flop synchronizer (asynchronous source).
//                   undefined -> inputs are used directly and must already be
//                                synchronous to clk_i.
//
// Ports:
//   clk_i     in   system clock, all state changes on its rising edge
//   rst_i     in   synchronous active-high reset
//   sck_i     in   I2S bit clock (must be high/low for >= 3 clk_i periods)
//   ws_i      in   I2S word select, 0 = left, 1 = right
//   sd_i      in   I2S serial data, MSB first
//   data_l_o  out  left word of the presented pair
//   data_r_o  out  right word of the presented pair
//   valid_o   out  pair presented, held until accepted
//   ready_i   in   consumer accepts the presented pair
//   ovf_o     out  sticky: a completed pair was dropped
//
// Receiver states:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   UNSYNC | no WS 1->0 seen since reset; words are discarded
//   LEFT   | receiving a left word (entered on a WS 1->0 boundary)
//   RIGHT  | receiving a right word; its end completes the pair
// ---------------------------------------------------------------------------
module i2s_rx_deser #(
    parameter int DW      = 24,
    parameter int CNT_RES = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sck_i,
    input  logic          ws_i,
    input  logic          sd_i,
    output logic [DW-1:0] data_l_o,
    output logic [DW-1:0] data_r_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          ovf_o
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2
    } state_t;

    localparam logic [CNT_RES-1:0] LP_LAST = CNT_RES'(DW - 1);

    logic w_sck;
    logic w_ws;
    logic w_sd;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] r_sck_sync;
    logic [1:0] r_ws_sync;
    logic [1:0] r_sd_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[0], sck_i};
            r_ws_sync  <= {r_ws_sync[0],  ws_i};
            r_sd_sync  <= {r_sd_sync[0],  sd_i};
        end
    end

    assign w_sck = r_sck_sync[1];
    assign w_ws  = r_ws_sync[1];
    assign w_sd  = r_sd_sync[1];
`else
    assign w_sck = sck_i;
    assign w_ws  = ws_i;
    assign w_sd  = sd_i;
`endif

    state_t             r_state;
    logic               r_sck_prev;
    logic               r_ws_prev;
    logic [CNT_RES-1:0] r_cnt;
    logic               r_sat;
    logic [DW-1:0]      r_shift;
    logic [DW-1:0]      r_hold_l;
    logic [DW-1:0]      r_hold_r;
    logic               r_left_ok;
    logic               r_pair_pend;

    logic               w_sck_rise;
    logic               w_boundary;
    logic [CNT_RES-1:0] w_idx;
    logic [DW-1:0]      w_bit_vec;
    logic [DW-1:0]      w_word;

    assign w_sck_rise = w_sck & ~r_sck_prev;
    // A WS change seen at an SCK rise marks the last bit of the ending word.
    assign w_boundary = w_sck_rise & (w_ws ^ r_ws_prev);

    // The bit count is {r_sat, r_cnt}: r_sat set means the count has reached
    // DW. Keeping the saturated state as a flag lets DW equal 2**CNT_RES
    // without widening the counter.
    assign w_idx     = LP_LAST - r_cnt;
    assign w_bit_vec = {{(DW-1){1'b0}}, w_sd} << w_idx;
    // Shift register including the bit of the current rise; bits past DW
    // are dropped so the word stays MSB-aligned.
    assign w_word    = r_sat ? r_shift : (r_shift | w_bit_vec);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_UNSYNC;
            r_sck_prev  <= 1'b0;
            r_ws_prev   <= 1'b0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_shift     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_left_ok   <= 1'b0;
            r_pair_pend <= 1'b0;
            data_l_o    <= '0;
            data_r_o    <= '0;
            valid_o     <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            r_sck_prev  <= w_sck;
            r_pair_pend <= 1'b0;

            if (w_sck_rise) begin
                r_ws_prev <= w_ws;
                if (w_boundary) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_sat   <= 1'b0;
                    case (r_state)
                        ST_UNSYNC: begin
                            if (!w_ws) begin
                                r_state   <= ST_LEFT;
                                r_left_ok <= 1'b0;
                            end
                        end
                        ST_LEFT: begin
                            if (w_ws) begin
                                r_hold_l  <= w_word;
                                r_left_ok <= 1'b1;
                                r_state   <= ST_RIGHT;
                            end
                        end
                        ST_RIGHT: begin
                            if (!w_ws) begin
                                r_hold_r    <= w_word;
                                r_pair_pend <= r_left_ok;
                                r_left_ok   <= 1'b0;
                                r_state     <= ST_LEFT;
                            end
                        end
                        default: begin
                            r_state <= ST_UNSYNC;
                        end
                    endcase
                end else begin
                    r_shift <= w_word;
                    if (!r_sat) begin
                        if (r_cnt == LP_LAST) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end

            // Output stage: a completed pair loads one cycle after capture.
            // An acceptance in that same cycle frees the slot, so the new pair
            // replaces the accepted one without an overflow.
            if (r_pair_pend) begin
                if (!valid_o || ready_i) begin
                    data_l_o <= r_hold_l;
                    data_r_o <= r_hold_r;
                    valid_o  <= 1'b1;
                end else begin
                    ovf_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
`timescale 1ns/1ps
module tb_i2s_rx_deser;

    localparam int DW      = 16;
    localparam int CNT_RES = 5;
`ifdef I2S_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sck;
    logic          ws;
    logic          sd;
    logic          ready;
    logic          valid;
    logic          ovf;
    logic [DW-1:0] dl;
    logic [DW-1:0] dr;

    always #5 clk = ~clk;

    i2s_rx_deser #(.DW(DW), .CNT_RES(CNT_RES)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sck_i    (sck),
        .ws_i     (ws),
        .sd_i     (sd),
        .data_l_o (dl),
        .data_r_o (dr),
        .valid_o  (valid),
        .ready_i  (ready),
        .ovf_o    (ovf)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: {left, right} pairs the consumer should receive, in order
    logic [2*DW-1:0] sb_q[$];

    // word-level reference model of the receiver
    logic          m_ws;
    bit            m_synced;
    bit            m_left_ok;
    logic [DW-1:0] m_left;
    bit            m_cur_active;
    logic          m_cur_ch;
    logic [31:0]   m_cur_val;
    int            m_cur_n;
    bit            m_cur_whole;
    bit            m_ovf;
    bit            ready_at_load;

    // serial transmitter state
    bit            have_pend;
    logic          pend_sd;

    // per-bit observation of the SCK-high phase
    bit            lat_check;
    int            lat_seen;
    int            raise_ready_j;
    logic          g_valid [4];
    logic [DW-1:0] g_dl    [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Received word from an n-bit transmitted word: MSB-aligned, truncated
    // to DW bits or zero-padded below.
    function automatic logic [DW-1:0] exp_word(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {32'd0, v} & ((64'd1 << n) - 64'd1);
        if (n >= DW) t = t >> (n - DW);
        else         t = t << (DW - n);
        return t[DW-1:0];
    endfunction

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (sb_q.size() > 0 && !ready_at_load) m_ovf = 1'b1;
        else                                   sb_q.push_back({l, r});
    endtask

    // A word of channel ch begins while the previous one ends.
    task automatic model_boundary(input logic ch, output bit comp);
        comp = 1'b0;
        if (m_cur_active && m_cur_whole) begin
            if (m_cur_ch == 1'b0) begin
                m_left    = exp_word(m_cur_val, m_cur_n);
                m_left_ok = 1'b1;
            end else if (m_left_ok) begin
                push_pair(m_left, exp_word(m_cur_val, m_cur_n));
                m_left_ok = 1'b0;
                comp      = 1'b1;
            end
        end
        if (ch == 1'b0) m_synced = 1'b1;
    endtask

    // One SCK period: 4 clk low (data changes), 4 clk high.
    task automatic emit(input logic w, input logic d, input bit meas);
        @(negedge clk);
        sck = 1'b0; ws = w; sd = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        lat_seen = -1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            g_valid[j] = valid;
            g_dl[j]    = dl;
            if (lat_seen < 0 && valid === 1'b1) lat_seen = j;
            if (j < 3) begin
                @(negedge clk);
                if (meas && raise_ready_j == j) ready = 1'b1;
            end
        end
        if (meas && lat_check) chk("latency_edges", lat_seen, LAT);
    endtask

    // I2S: the previous word's LSB is sent with the new WS value.
    task automatic tx_word(input logic ch, input logic [31:0] val, input int n);
        bit comp;
        comp = 1'b0;
        if (ch != m_ws) model_boundary(ch, comp);
        m_ws = ch;
        if (have_pend) emit(ch, pend_sd, comp);
        m_cur_active = 1'b1;
        m_cur_ch     = ch;
        m_cur_val    = val;
        m_cur_n      = n;
        m_cur_whole  = m_synced;
        for (int i = n - 1; i >= 1; i--) emit(ch, val[i], 1'b0);
        pend_sd   = val[0];
        have_pend = 1'b1;
    endtask

    // Send the pending LSB with WS=0, ending the right word.
    task automatic tx_close();
        bit comp;
        comp = 1'b0;
        if (m_ws != 1'b0) model_boundary(1'b0, comp);
        m_ws = 1'b0;
        if (have_pend) emit(1'b0, pend_sd, comp);
        have_pend    = 1'b0;
        m_cur_active = 1'b0;
    endtask

    task automatic frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
        tx_word(1'b0, l, nl);
        tx_word(1'b1, r, nr);
        tx_close();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("pairs_outstanding_at_reset", sb_q.size(), 0);
        sb_q.delete();
        m_ws = 1'b0; m_synced = 1'b0; m_left_ok = 1'b0;
        m_cur_active = 1'b0; m_ovf = 1'b0; have_pend = 1'b0;
    endtask

    // monitor: a pair is transferred at an edge where valid && ready
    initial begin
        logic [2*DW-1:0] e;
        forever begin
            @(negedge clk); #1;
            if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair actual=%0h/%0h required=none", dl, dr);
                end else begin
                    e = sb_q.pop_front();
                    chk("pair_left", dl, e[2*DW-1:DW]);
                    chk("pair_right", dr, e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a_l, a_r, b_l, b_r, rl, rr, mk;
        int          nl, nr;
        rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b1;
        ready_at_load = 1'b1; lat_check = 1'b0; raise_ready_j = -1;
        m_ws = 1'b0; m_synced = 1'b0; m_left_ok = 1'b0; m_left = '0;
        m_cur_active = 1'b0; m_cur_ch = 1'b0; m_cur_val = '0; m_cur_n = 0;
        m_cur_whole = 1'b0; m_ovf = 1'b0; have_pend = 1'b0; pend_sd = 1'b0;

        do_reset();
        chk("rst_data_l", dl, 0);
        chk("rst_data_r", dr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);

        // basic frame after a WS 1->0
        tx_word(1'b1, $urandom & 32'hFFFF, 16);
        lat_check = 1'b1;
        frame(32'hA5C3, 16, 32'h3C5A, 16);
        lat_check = 1'b0;
        chk("basic_l", dl, 16'hA5C3);
        chk("basic_r", dr, 16'h3C5A);
        chk("basic_ovf", ovf, m_ovf);

        // start mid-word after reset: first frame must not be presented
        do_reset();
        tx_word(1'b0, $urandom & 32'h7F, 7);
        tx_word(1'b1, $urandom & 32'hFFFF, 16);
        frame(32'h1234, 16, 32'h5678, 16);
        chk("resync_l", dl, 16'h1234);
        chk("resync_r", dr, 16'h5678);

        // short and long words
        frame(32'hABC, 12, $urandom & 32'hFFF, 12);
        chk("short_l", dl, 16'hABC0);
        frame(32'hFEDCB, 20, $urandom & 32'hFFFFF, 20);
        chk("long_l", dl, 16'hFEDC);

        // random frames, random lengths
        for (int k = 0; k < 6; k++) begin
            nl = $urandom_range(8, 22);
            nr = $urandom_range(8, 22);
            mk = (32'd1 << nl) - 32'd1; rl = $urandom & mk;
            mk = (32'd1 << nr) - 32'd1; rr = $urandom & mk;
            frame(rl, nl, rr, nr);
        end
        chk("random_ovf", ovf, m_ovf);

        // back-pressure: second pair dropped
        @(negedge clk); ready = 1'b0; ready_at_load = 1'b0;
        frame(32'h1111, 16, 32'h2222, 16);
        frame(32'h3333, 16, 32'h4444, 16);
        repeat (10) @(negedge clk);
        chk("hold_l", dl, 16'h1111);
        chk("hold_r", dr, 16'h2222);
        chk("hold_valid", valid, 1);
        chk("ovf_set", ovf, m_ovf);
        @(negedge clk); ready = 1'b1; ready_at_load = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", valid, 0);

        // reset in the middle of a right word
        tx_word(1'b0, $urandom & 32'hFFFF, 16);
        tx_word(1'b1, $urandom & 32'hFF, 8);
        do_reset();
        chk("midrst_data_l", dl, 0);
        chk("midrst_data_r", dr, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_ovf", ovf, 0);
        tx_word(1'b1, $urandom & 32'hFF, 8);
        a_l = $urandom & 32'hFFFF;
        a_r = $urandom & 32'hFFFF;
        lat_check = 1'b1;
        frame(a_l, 16, a_r, 16);
        lat_check = 1'b0;
        chk("post_rst_l", dl, a_l);

        // ready rises in the very cycle the next pair loads
        @(negedge clk); ready = 1'b0; ready_at_load = 1'b0;
        a_l = $urandom & 32'hFFFF; a_r = $urandom & 32'hFFFF;
        b_l = $urandom & 32'hFFFF; b_r = $urandom & 32'hFFFF;
        frame(a_l, 16, a_r, 16);
        tx_word(1'b0, b_l, 16);
        tx_word(1'b1, b_r, 16);
        ready_at_load = 1'b1;
        raise_ready_j = LAT - 1;
        tx_close();
        raise_ready_j = -1;
        chk("same_cycle_valid_before", g_valid[LAT-1], 1);
        chk("same_cycle_dl_before", g_dl[LAT-1], a_l);
        chk("same_cycle_valid_after", g_valid[LAT], 1);
        chk("same_cycle_dl_after", g_dl[LAT], b_l);
        chk("same_cycle_ovf", ovf, m_ovf);

        repeat (20) @(negedge clk);
        chk("pairs_outstanding_end", sb_q.size(), 0);
        chk("end_valid", valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
